// File: rtl/i2s_tx_gen.sv
// i2s_tx_gen: parametrised I2S/left-justified/TDM serial audio frame transmitter
module i2s_tx_gen #(
  parameter int DATA_W = 24,
  parameter int SLOT_W = 32,
  parameter int CHANNELS = 2,
  parameter int BCK_DIV = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       enable,
  input  logic                       fmt,
  input  logic                       mute,
  input  logic [CHANNELS*DATA_W-1:0] s_data,
  input  logic                       s_valid,
  output logic                       s_ready,
  output logic                       bck,
  output logic                       lrck,
  output logic                       sdata,
  output logic                       frame_start,
  output logic                       underrun
);
  localparam int FB = CHANNELS * SLOT_W;
  localparam int CW = FB > 1 ? $clog2(FB) : 1;
  localparam int AW = CHANNELS * DATA_W > 1 ? $clog2(CHANNELS * DATA_W) : 1;
  localparam int DVW = BCK_DIV > 1 ? $clog2(BCK_DIV) : 1;
  localparam int PAD = SLOT_W - DATA_W;
  logic [DVW-1:0] div_cnt;
  logic [CW-1:0] bit_cnt, bit_nx;
  logic [AW-1:0] idx;
  logic [CHANNELS*DATA_W-1:0] hold, active, act_nx;
  logic hold_full, d, tick, fall, load, xfer, bit_val;
  int p, ch, k;
  assign s_ready = !hold_full;
  // the bit emitted on a load fall already comes from the newly loaded frame
  always_comb begin
    tick = div_cnt == DVW'(BCK_DIV - 1);
    fall = enable && tick && bck;
    bit_nx = bit_cnt == CW'(FB - 1) ? '0 : bit_cnt + 1'b1;
    load = fall && bit_nx == CW'(d);
    act_nx = load ? (hold_full && !mute ? hold : '0) : active;
    p = (int'(bit_nx) - int'(d) + FB) % FB;
    ch = p / SLOT_W;
    k = SLOT_W - 1 - p % SLOT_W;
    idx = AW'(ch * DATA_W + k - PAD);
    bit_val = k >= PAD && act_nx[idx];
    xfer = s_valid && s_ready;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      div_cnt <= '0;
      bck <= 1'b0;
      bit_cnt <= CW'(FB - 1);
      lrck <= 1'b0;
      sdata <= 1'b0;
      frame_start <= 1'b0;
      underrun <= 1'b0;
      hold_full <= 1'b0;
      hold <= '0;
      active <= '0;
      d <= !fmt;
    end else begin
      frame_start <= load;
      underrun <= load && !hold_full;
      hold_full <= xfer || (hold_full && !load);
      if (xfer) hold <= s_data;
      active <= act_nx;
      if (!enable) begin
        div_cnt <= '0;
        bck <= 1'b0;
        bit_cnt <= CW'(FB - 1);
        lrck <= 1'b0;
        sdata <= 1'b0;
        d <= !fmt;
      end else begin
        div_cnt <= tick ? '0 : div_cnt + 1'b1;
        if (tick) bck <= !bck;
        if (fall) begin
          bit_cnt <= bit_nx;
          lrck <= CHANNELS == 2 ? bit_nx >= CW'(SLOT_W) : bit_nx == '0;
          sdata <= bit_val;
        end
      end
    end
  end
endmodule
